// File: rtl/imem_loader.sv
// Serial program loader: assembles big-endian bytes into instruction words, writes them
// to instruction memory, then releases the CPU. Optional XOR checksum: IMEM_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for the first program byte
// LOAD  | collecting bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// READY | program loaded, waiting for i_start
// RUN   | CPU enabled, waiting for i_halt
// DONE  | program finished; only reset leaves
module imem_loader #(
  parameter int                NBITS     = 32,
  parameter int                CELDAS    = 60,
  parameter logic [NBITS-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_start,
  input  logic             i_halt,
  output logic             o_mem_wr_en,
  output logic [NBITS-1:0] o_mem_addr,
  output logic [NBITS-1:0] o_mem_wr_data,
  output logic             o_cpu_en,
  output logic             o_loading,
  output logic             o_done,
  output logic [NBITS-1:0] o_word_count,
  output logic [NBITS-1:0] o_checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, READY, RUN, DONE} state_t;

  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - 4);

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [NBITS-1:0] addr;
  logic [NBITS-1:0] word;

  assign o_mem_addr    = addr;
  assign o_mem_wr_data = word;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      addr         <= '0;
      word         <= '0;
      o_mem_wr_en  <= 1'b0;
      o_cpu_en     <= 1'b0;
      o_loading    <= 1'b0;
      o_done       <= 1'b0;
      o_word_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            word      <= NBITS'(i_rx_data);
            byte_cnt  <= 2'd1;
            o_loading <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (i_rx_valid) begin
            word <= {word[NBITS-9:0], i_rx_data};
            if (byte_cnt == 2'd3) begin
              byte_cnt    <= 2'd0;
              o_mem_wr_en <= 1'b1;
              state       <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          o_mem_wr_en  <= 1'b0;
          addr         <= addr + NBITS'(4);
          o_word_count <= o_word_count + NBITS'(1);
          // Stopping at the last cell is what keeps the address from ever wrapping.
          if (word == HALT_WORD || addr == LAST_ADDR) begin
            o_loading <= 1'b0;
            state     <= READY;
          end else begin
            state <= LOAD;
            if (i_rx_valid) begin
              word     <= NBITS'(i_rx_data);
              byte_cnt <= 2'd1;
            end
          end
        end
        READY: begin
          if (i_start) begin
            o_cpu_en <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (i_halt) begin
            o_cpu_en <= 1'b0;
            o_done   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [NBITS-1:0] checksum;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      checksum <= '0;
    else if (state == WRITE)
      checksum <= checksum ^ word;
  end

  assign o_checksum = checksum;
`else
  assign o_checksum = '0;
`endif

endmodule
